// File: rtl/serial_mag_comp.sv
// Serial N-bit magnitude comparator: one 2-bit cascade slice per cycle, MSB slice first.
// Latency: start accepted at edge 0, done pulse and EQ/GT/LT valid after edge WIDTH/2.
// Backpressure: none; start is ignored while busy, and accepted in the done cycle for gapless reuse.

// 2-bit cascade slice. A decision from a more significant slice (eq1=0) passes
// straight through. Otherwise this slice compares its own pair of bits.
module mag_slice2 (
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   input  logic       eq1_i,
   input  logic       gt1_i,
   output logic       eq0_o,
   output logic       gt0_o
);

   // Pure cascade rule; (eq1,gt1)=(1,1) never arrives from upstream.
   always_comb begin
      eq0_o = 1'b0;
      gt0_o = gt1_i;
      if (eq1_i) begin
         eq0_o = (a_i == b_i);
         gt0_o = (a_i > b_i);
      end
   end

endmodule

module serial_mag_comp #(
   parameter int WIDTH = 8   // even, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic             busy,
   output logic             done,
   output logic             EQ,
   output logic             GT,
   output logic             LT
);

   localparam int NSLICE = WIDTH / 2;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx_q;
   logic             eq_acc_q;
   logic             gt_acc_q;
   logic             busy_q;
   logic             done_q;
   logic             eq_q;
   logic             gt_q;
   logic             lt_q;

   // Slice outputs are the next cascade state.
   logic             eq_acc_d;
   logic             gt_acc_d;

   // Operands are shifted left each cycle, so the slice under test is always
   // the top two bits; idx_q only counts how many slices remain.
   mag_slice2 u_slice (
      .a_i   (a_q[WIDTH-1 -: 2]),
      .b_i   (b_q[WIDTH-1 -: 2]),
      .eq1_i (eq_acc_q),
      .gt1_i (gt_acc_q),
      .eq0_o (eq_acc_d),
      .gt0_o (gt_acc_d)
   );

   // Control FSM, operand shifter, cascade state and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         eq_acc_q <= 1'b1;
         gt_acc_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         eq_q     <= 1'b0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q      <= A_in;
                  b_q      <= B_in;
                  eq_acc_q <= 1'b1;
                  gt_acc_q <= 1'b0;
                  idx_q    <= IW'(NSLICE - 1);
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               a_q      <= a_q << 2;
               b_q      <= b_q << 2;
               eq_acc_q <= eq_acc_d;
               gt_acc_q <= gt_acc_d;
               // No early exit: the last slice always closes the operation,
               // keeping latency independent of the operand values.
               if (idx_q == '0) begin
                  eq_q    <= eq_acc_d;
                  gt_q    <= gt_acc_d & ~eq_acc_d;
                  lt_q    <= ~eq_acc_d & ~gt_acc_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  idx_q <= idx_q - IW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign EQ   = eq_q;
   assign GT   = gt_q;
   assign LT   = lt_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: WIDTH=8 directed/table vectors and WIDTH=4 exhaustive.
// Expected results are queued at start and matched when done pulses, with latency checked.
// Start pulses while busy and reset mid-operation must produce no done.
module tb_serial_mag_comp;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start4;
   logic [7:0] a8, b8;
   logic [3:0] a4, b4;
   logic       busy8, done8, eq8, gt8, lt8;
   logic       busy4, done4, eq4, gt4, lt4;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int done8_cnt = 0, done4_cnt = 0;
   int pushed8 = 0, pushed4 = 0;

   typedef struct {
      logic eq;
      logic gt;
      logic lt;
      int   acc;   // cycle number of the edge that accepts start
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       eq;
      logic       gt;
      logic       lt;
   } vec_t;

   exp_t q8[$];
   exp_t q4[$];
   exp_t e8, e4;
   vec_t vecs[10];

   serial_mag_comp #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .A_in(a8), .B_in(b8),
      .busy(busy8), .done(done8), .EQ(eq8), .GT(gt8), .LT(lt8)
   );

   serial_mag_comp #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .A_in(a4), .B_in(b4),
      .busy(busy4), .done(done4), .EQ(eq4), .GT(gt4), .LT(lt4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard for the 8-bit instance: every done must match the oldest queued op.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         done8_cnt++;
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done8_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            e8 = q8.pop_front();
            check("res8", {29'd0, eq8, gt8, lt8}, {29'd0, e8.eq, e8.gt, e8.lt});
            check("lat8", cyc - e8.acc, 4);
         end
      end
   end

   // Scoreboard for the 4-bit instance.
   always @(negedge clk) begin
      if (done4 === 1'b1) begin
         done4_cnt++;
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done4_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            e4 = q4.pop_front();
            check("res4", {29'd0, eq4, gt4, lt4}, {29'd0, e4.eq, e4.gt, e4.lt});
            check("lat4", cyc - e4.acc, 2);
         end
      end
   end

   task automatic launch8(input logic [7:0] a, input logic [7:0] b,
                          input logic eq, input logic gt, input logic lt, input bit push);
      start8 = 1'b1;
      a8     = a;
      b8     = b;
      if (push) begin
         q8.push_back('{eq, gt, lt, cyc + 1});
         pushed8++;
      end
      tick();
      start8 = 1'b0;
   endtask

   task automatic launch4(input logic [3:0] a, input logic [3:0] b,
                          input logic eq, input logic gt, input logic lt);
      start4 = 1'b1;
      a4     = a;
      b4     = b;
      q4.push_back('{eq, gt, lt, cyc + 1});
      pushed4++;
      tick();
      start4 = 1'b0;
   endtask

   task automatic wait_done8();
      int n = 0;
      while (done8 !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (done8 !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL timeout8: got no done expected done within 20 cycles");
      end
   endtask

   task automatic wait_done4();
      int n = 0;
      while (done4 !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (done4 !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL timeout4: got no done expected done within 20 cycles");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'hA6, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h40, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{8'h01, 8'h02, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{8'h3C, 8'h3B, 1'b0, 1'b1, 1'b0};

      rst = 1'b1;
      start8 = 1'b0; start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      tick();
      tick();
      check("rst8_outs", {27'd0, busy8, done8, eq8, gt8, lt8}, 32'd0);
      check("rst4_outs", {27'd0, busy4, done4, eq4, gt4, lt4}, 32'd0);
      rst = 1'b0;
      tick();

      // Equal operands: busy for 4 samples, then a single-cycle done.
      launch8(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("seq1_busy", {30'd0, busy8, done8}, 32'b10);
         tick();
      end
      check("seq1_done", {30'd0, busy8, done8}, 32'b01);
      tick();
      check("seq1_done_drop", {31'd0, done8}, 32'd0);

      // Table vectors, each checked by the scoreboard, plus done pulse width.
      for (int v = 0; v < 10; v++) begin
         launch8(vecs[v].a, vecs[v].b, vecs[v].eq, vecs[v].gt, vecs[v].lt, 1'b1);
         wait_done8();
         tick();
         check("tbl_done_pulse", {31'd0, done8}, 32'd0);
      end

      // Decided on MSB slice; operand inputs change while busy.
      launch8(8'h40, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
      a8 = 8'hFF;
      b8 = 8'h00;
      wait_done8();

      // Back-to-back: start in the done cycle, then a stray start mid-op.
      launch8(8'h10, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1);
      check("b2b_no_bubble", {30'd0, busy8, done8}, 32'b10);
      tick();
      launch8(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_done8();
      repeat (8) tick();

      // Reset after edge 2 of an operation aborts it and clears results.
      launch8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_outs", {27'd0, busy8, done8, eq8, gt8, lt8}, 32'd0);
      repeat (6) tick();
      check("midrst_hold", {27'd0, busy8, done8, eq8, gt8, lt8}, 32'd0);
      launch8(8'h34, 8'h12, 1'b0, 1'b1, 1'b0, 1'b1);
      wait_done8();
      tick();

      // WIDTH=4 exhaustive against integer compare.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            launch4(a[3:0], b[3:0], a == b, a > b, a < b);
            wait_done4();
         end
      end
      repeat (4) tick();

      check("ndone8", done8_cnt, pushed8);
      check("ndone4", done4_cnt, pushed4);
      check("q8_drained", q8.size(), 0);
      check("q4_drained", q4.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
